// File: rtl/kbd_port_arbiter.sv
// kbd_port_arbiter: hands one shared PS/2 keyboard instance to host port A or B.
// A handover drains the current owner until its host has been idle long enough,
// then pulses kbd_reset into the new owner.
// Optional feature macro: KBD_ARB_TIMEOUT_EN adds a DRAIN clock counter that
// forces the handover after TIMEOUT clocks even if the host never goes idle.
module kbd_port_arbiter #(
    parameter int unsigned IDLE_CYCLES = 32,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_kbd_a,
    input  logic        cfg_kbd_b,
    input  logic [10:0] ps2_key,
    input  logic [6:0]  pa_o,
    input  logic [6:0]  pa_d,
    input  logic [6:0]  pb_o,
    input  logic [6:0]  pb_d,
    input  logic [6:0]  pad_a_i,
    input  logic [6:0]  pad_b_i,
    input  logic [6:0]  kbd_port_i,
    output logic [6:0]  kbd_port_o,
    output logic [6:0]  kbd_port_d,
    output logic [10:0] kbd_ps2_key,
    output logic        kbd_enable,
    output logic        kbd_reset,
    output logic [6:0]  pa_i_out,
    output logic [6:0]  pb_i_out,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam int unsigned PIN_W  = 7;
    localparam int unsigned KEY_W  = 11;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          target;
    logic [PIN_W-1:0]    own_o;
    logic [PIN_W-1:0]    own_d;
    logic                host_idle;
    logic                idle_done;
    logic                timeout_hit;
    logic                run_entry;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_cnt_nxt;
    logic                tgl_ref;
    logic                tgl_ref_nxt;
    logic [1:0]          owner_nxt;
    logic                kbd_enable_nxt;
    logic                kbd_reset_nxt;
    logic                busy_nxt;
    logic [KEY_W-1:0]    kbd_ps2_key_nxt;

    // Requested owner: A has priority over B.
    always_comb begin
        target = OWN_NONE;
        if (cfg_kbd_a) begin
            target = OWN_A;
        end else if (cfg_kbd_b) begin
            target = OWN_B;
        end
    end

    // Owner port's o/d images; all-ones (released, inputs) when nobody owns the keyboard.
    always_comb begin
        own_o = 7'h7F;
        own_d = 7'h7F;
        case (owner)
            OWN_A: begin
                own_o = pa_o;
                own_d = pa_d;
            end
            OWN_B: begin
                own_o = pb_o;
                own_d = pb_d;
            end
            default: ;
        endcase
    end

    assign kbd_port_o = own_o;
    assign kbd_port_d = own_d;

    // Pin images back to the hosts: the owner sees the keyboard, the other its pad.
    assign pa_i_out = (owner == OWN_A) ? kbd_port_i : pad_a_i;
    assign pb_i_out = (owner == OWN_B) ? kbd_port_i : pad_b_i;

    // Host is idle when it drives both clock/data lines released high as outputs.
    assign host_idle = (own_d[6:5] == 2'b00) && (own_o[6:5] == 2'b11);
    assign idle_done = host_idle && (idle_cnt >= IDLE_W'(IDLE_CYCLES - 1));

`ifdef KBD_ARB_TIMEOUT_EN
    localparam int unsigned DRAIN_W = $clog2(TIMEOUT + 1);

    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_nxt;

    assign timeout_hit = (state == ST_DRAIN) && (drain_cnt >= DRAIN_W'(TIMEOUT - 1));

    // DRAIN clock count; cleared whenever the block is not staying in DRAIN.
    always_comb begin
        drain_cnt_nxt = '0;
        if ((state == ST_DRAIN) && (state_nxt == ST_DRAIN)) begin
            drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
        end
    end

    // DRAIN clock counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt_nxt;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Next-state logic and host-idle run length while draining.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (target != OWN_NONE) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (target != owner) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (target == owner) begin
                    state_nxt = ST_RUN;
                end else if (idle_done || timeout_hit) begin
                    state_nxt = ST_SWITCH;
                end else if (host_idle && (idle_cnt < IDLE_W'(IDLE_CYCLES))) begin
                    idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            ST_SWITCH: begin
                state_nxt = (target != OWN_NONE) ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        run_entry       = (state_nxt == ST_RUN) &&
                          ((state == ST_IDLE) || (state == ST_SWITCH));
        kbd_enable_nxt  = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
        busy_nxt        = (state_nxt == ST_DRAIN) || (state_nxt == ST_SWITCH);
        owner_nxt       = OWN_NONE;
        kbd_reset_nxt   = 1'b0;
        tgl_ref_nxt     = tgl_ref;
        kbd_ps2_key_nxt = '0;
        if (run_entry) begin
            owner_nxt     = target;
            kbd_reset_nxt = 1'b1;
            tgl_ref_nxt   = ps2_key[10];
        end else if (kbd_enable_nxt) begin
            owner_nxt = owner;
        end
        // Rebase the toggle so a fresh owner sees no phantom event at entry.
        if (kbd_enable_nxt) begin
            kbd_ps2_key_nxt = {ps2_key[10] ^ tgl_ref_nxt, ps2_key[9:0]};
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idle_cnt    <= '0;
            tgl_ref     <= 1'b0;
            owner       <= OWN_NONE;
            kbd_enable  <= 1'b0;
            kbd_reset   <= 1'b0;
            busy        <= 1'b0;
            kbd_ps2_key <= '0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_cnt_nxt;
            tgl_ref     <= tgl_ref_nxt;
            owner       <= owner_nxt;
            kbd_enable  <= kbd_enable_nxt;
            kbd_reset   <= kbd_reset_nxt;
            busy        <= busy_nxt;
            kbd_ps2_key <= kbd_ps2_key_nxt;
        end
    end

endmodule

// File: tb/tb_kbd_port_arbiter.sv
// Testbench for kbd_port_arbiter: constant vector table, directed corner
// sequences and randomized traffic against a phase-level reference model.
module tb_kbd_port_arbiter;

    localparam int unsigned IDLE_N = 32;
    localparam int unsigned TO_N   = 4096;
`ifdef KBD_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_kbd_a, cfg_kbd_b;
    logic [10:0] ps2_key;
    logic [6:0]  pa_o, pa_d, pb_o, pb_d, pad_a_i, pad_b_i, kbd_port_i;
    logic [6:0]  kbd_port_o, kbd_port_d, pa_i_out, pb_i_out;
    logic [10:0] kbd_ps2_key;
    logic        kbd_enable, kbd_reset, busy;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 keyboard running, 2 draining, 3 switching.
    int          m_phase;
    logic [1:0]  m_owner;
    int          m_idle_run;
    int          m_drain_clks;
    logic        m_tref;
    logic        m_kreset;
    logic [10:0] m_key;

    always #5 clk = ~clk;

    kbd_port_arbiter #(.IDLE_CYCLES(IDLE_N), .TIMEOUT(TO_N)) dut (
        .clk(clk), .reset(reset), .cfg_kbd_a(cfg_kbd_a), .cfg_kbd_b(cfg_kbd_b),
        .ps2_key(ps2_key), .pa_o(pa_o), .pa_d(pa_d), .pb_o(pb_o), .pb_d(pb_d),
        .pad_a_i(pad_a_i), .pad_b_i(pad_b_i), .kbd_port_i(kbd_port_i),
        .kbd_port_o(kbd_port_o), .kbd_port_d(kbd_port_d), .kbd_ps2_key(kbd_ps2_key),
        .kbd_enable(kbd_enable), .kbd_reset(kbd_reset), .pa_i_out(pa_i_out),
        .pb_i_out(pb_i_out), .owner(owner), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs present before it.
    task automatic model_advance();
        logic [1:0] tgt;
        logic [6:0] oo, dd;
        bit         hidle;
        int         nph;
        if (reset) begin
            m_phase = 0; m_owner = 2'b00; m_idle_run = 0; m_drain_clks = 0;
            m_tref = 1'b0; m_kreset = 1'b0; m_key = 11'h000;
            return;
        end
        tgt = cfg_kbd_a ? 2'b01 : (cfg_kbd_b ? 2'b10 : 2'b00);
        oo = (m_owner == 2'b01) ? pa_o : (m_owner == 2'b10) ? pb_o : 7'h7F;
        dd = (m_owner == 2'b01) ? pa_d : (m_owner == 2'b10) ? pb_d : 7'h7F;
        hidle = (dd[6:5] == 2'b00) && (oo[6:5] == 2'b11);
        m_kreset = 1'b0;
        nph = m_phase;
        if ((m_phase == 0 || m_phase == 3) && tgt != 2'b00) begin
            nph = 1; m_owner = tgt; m_kreset = 1'b1; m_tref = ps2_key[10];
        end else if (m_phase == 3) begin
            nph = 0;
        end else if (m_phase == 1 && tgt != m_owner) begin
            nph = 2; m_idle_run = 0; m_drain_clks = 0;
        end else if (m_phase == 2) begin
            if (tgt == m_owner) begin
                nph = 1;
            end else begin
                m_drain_clks++;
                m_idle_run = hidle ? m_idle_run + 1 : 0;
                if (m_idle_run >= IDLE_N || (TO_EN && m_drain_clks >= TO_N)) begin
                    nph = 3; m_owner = 2'b00;
                end
            end
        end
        m_phase = nph;
        m_key = (nph == 1 || nph == 2) ? {ps2_key[10] ^ m_tref, ps2_key[9:0]} : 11'h000;
    endtask

    task automatic check_all();
        chk("owner", 32'(owner), 32'(m_owner));
        chk("kbd_enable", 32'(kbd_enable), 32'(m_phase == 1 || m_phase == 2));
        chk("kbd_reset", 32'(kbd_reset), 32'(m_kreset));
        chk("busy", 32'(busy), 32'(m_phase == 2 || m_phase == 3));
        chk("kbd_ps2_key", 32'(kbd_ps2_key), 32'(m_key));
        chk("kbd_port_o", 32'(kbd_port_o),
            32'((m_owner == 2'b01) ? pa_o : (m_owner == 2'b10) ? pb_o : 7'h7F));
        chk("kbd_port_d", 32'(kbd_port_d),
            32'((m_owner == 2'b01) ? pa_d : (m_owner == 2'b10) ? pb_d : 7'h7F));
        chk("pa_i_out", 32'(pa_i_out), 32'((m_owner == 2'b01) ? kbd_port_i : pad_a_i));
        chk("pb_i_out", 32'(pb_i_out), 32'((m_owner == 2'b10) ? kbd_port_i : pad_b_i));
    endtask

    // One clock: model the edge, let the DUT take it, compare just after.
    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_host(input bit port_b, input bit idle);
        logic [6:0] o, d;
        o = idle ? 7'h7F : 7'h1F;
        d = idle ? 7'h00 : 7'h7F;
        if (port_b) begin pb_o = o; pb_d = d; end
        else begin pa_o = o; pa_d = d; end
    endtask

    typedef struct {
        bit         a;
        bit         b;
        bit         pa_idle;
        bit         pb_idle;
        int         reps;
        logic [1:0] owner;
        bit         en;
        bit         rst;
        bit         busy;
    } vec_t;

    vec_t vecs[13];
    int   sw_at;
    bit   idle_a, idle_b;

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 2,  2'b00, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 1,  2'b01, 1, 1, 0};
        vecs[2]  = '{1, 0, 0, 0, 1,  2'b01, 1, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 3,  2'b01, 1, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 1,  2'b01, 1, 0, 1};
        vecs[5]  = '{0, 1, 1, 0, 31, 2'b01, 1, 0, 1};
        vecs[6]  = '{0, 1, 1, 0, 1,  2'b00, 0, 0, 1};
        vecs[7]  = '{0, 1, 1, 0, 1,  2'b10, 1, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 1,  2'b10, 1, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 1,  2'b10, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 1,  2'b10, 1, 0, 1};
        vecs[11] = '{0, 0, 0, 1, 32, 2'b00, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 1, 1,  2'b00, 0, 0, 0};

        reset = 1'b1; cfg_kbd_a = 1'b0; cfg_kbd_b = 1'b0; ps2_key = 11'h000;
        set_host(0, 0); set_host(1, 0);
        pad_a_i = 7'h2A; pad_b_i = 7'h55; kbd_port_i = 7'h33;
        step(); step();
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_enable", 32'(kbd_enable), 32'd0);
        chk("rst_kreset", 32'(kbd_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_key", 32'(kbd_ps2_key), 32'd0);
        reset = 1'b0;

        // Vector table: inputs held for reps clocks, then outputs compared.
        for (int i = 0; i < 13; i++) begin
            cfg_kbd_a = vecs[i].a; cfg_kbd_b = vecs[i].b;
            set_host(0, vecs[i].pa_idle); set_host(1, vecs[i].pb_idle);
            for (int r = 0; r < vecs[i].reps; r++) step();
            chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
            chk($sformatf("vec%0d_enable", i), 32'(kbd_enable), 32'(vecs[i].en));
            chk($sformatf("vec%0d_kreset", i), 32'(kbd_reset), 32'(vecs[i].rst));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end

        // Idle run broken at its 31st clock restarts the full count.
        cfg_kbd_a = 1'b1; set_host(0, 0); step();
        cfg_kbd_a = 1'b0; cfg_kbd_b = 1'b1; set_host(0, 1); step();
        for (int i = 0; i < 30; i++) step();
        set_host(0, 0); step();
        set_host(0, 1);
        for (int i = 0; i < 31; i++) step();
        chk("rerun_still_drain", 32'({owner, busy}), 32'({2'b01, 1'b1}));
        ps2_key = 11'h7FF; step();
        chk("switch_owner", 32'(owner), 32'd0);
        chk("switch_key_dropped", 32'(kbd_ps2_key), 32'h000);
        ps2_key = 11'h45A; step();
        chk("entry_key_rebased", 32'(kbd_ps2_key), 32'h05A);
        chk("entry_owner_b", 32'(owner), 32'd2);
        ps2_key = 11'h21C; step();
        chk("event_key", 32'(kbd_ps2_key), 32'h61C);

        // Reset while running drops enable with no keyboard reset pulse.
        reset = 1'b1; step();
        chk("midreset_enable", 32'(kbd_enable), 32'd0);
        chk("midreset_kreset", 32'(kbd_reset), 32'd0);
        reset = 1'b0; cfg_kbd_b = 1'b0;

        // Host never idle: handover only through the optional timeout.
        cfg_kbd_a = 1'b1; set_host(0, 0); step(); step();
        cfg_kbd_a = 1'b0; cfg_kbd_b = 1'b1; step();
        sw_at = 0;
        for (int n = 1; n <= 5000; n++) begin
            step();
            if (!kbd_enable) begin sw_at = n; break; end
        end
        chk("timeout_switch_clk", 32'(sw_at), TO_EN ? 32'(TO_N) : 32'd0);

        // Randomized traffic against the model.
        idle_a = 1'b0; idle_b = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) cfg_kbd_a = ~cfg_kbd_a;
            if ($urandom_range(0, 39) == 0) cfg_kbd_b = ~cfg_kbd_b;
            if ($urandom_range(0, 15) == 0) idle_a = ~idle_a;
            if ($urandom_range(0, 15) == 0) idle_b = ~idle_b;
            pa_o = idle_a ? (7'h60 | 7'($urandom_range(0, 31))) : 7'($urandom);
            pa_d = idle_a ? 7'($urandom_range(0, 31)) : 7'($urandom);
            pb_o = idle_b ? (7'h60 | 7'($urandom_range(0, 31))) : 7'($urandom);
            pb_d = idle_b ? 7'($urandom_range(0, 31)) : 7'($urandom);
            if ($urandom_range(0, 7) == 0) ps2_key = 11'($urandom);
            pad_a_i = 7'($urandom); pad_b_i = 7'($urandom); kbd_port_i = 7'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
